// File: rtl/clk_switch_ctrl_if.sv
// Request/response handshake between a clock-select requester and clk_switch_ctrl.
//   req_valid_i : request valid (requester -> sequencer)
//   req_sel_i   : requested source, 0 = A, 1 = B; stable while req_valid_i is high
//   req_ready_o : request accepted when high together with req_valid_i
//   rsp_valid_o : one-cycle completion pulse per accepted request
//   rsp_err_o   : qualified by rsp_valid_o; 1 = refused or reverted
interface clk_switch_ctrl_if;
    logic req_valid_i;
    logic req_sel_i;
    logic req_ready_o;
    logic rsp_valid_o;
    logic rsp_err_o;

    modport master (
        output req_valid_i,
        output req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_err_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_err_o
    );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitch-free clock mux, clocked by an always-on reference.
// Accepts select requests, checks target health, drives the mux select, waits a
// settle window, and reports completion/error. Fails over automatically when the
// active source dies and reverts an in-flight switch whose target dies.
// Ports:
//   clk_i, rst_i            : reference clock, async active-high reset
//   bus (slave)             : request/response handshake
//   clk_a_ok_i, clk_b_ok_i  : source health, already synchronous to clk_i
//   mux_sel_o               : registered mux select
//   cur_sel_o               : last completed, settled selection
//   busy_o                  : high in any state other than IDLE
//   failover_o              : one-cycle pulse when an automatic failover starts
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter bit          RESET_SEL     = 1'b0,
    parameter bit          AUTO_FAILOVER = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    clk_switch_ctrl_if.slave   bus,
    input  logic               clk_a_ok_i,
    input  logic               clk_b_ok_i,
    output logic               mux_sel_o,
    output logic               cur_sel_o,
    output logic               busy_o,
    output logic               failover_o
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESP   = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_REVERT = 2'd3;

    logic [1:0]       state, state_n;
    logic             tgt, tgt_n;
    logic             own, own_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             mux_n, cur_n;
    logic             rsp_valid_q, rsp_valid_n;
    logic             rsp_err_q, rsp_err_n;
    logic             failover_n;
    logic             busy_n;

    logic [1:0] ok;
    logic       fo_trig_c;

    assign ok = {clk_b_ok_i, clk_a_ok_i};

    // Active source lost while the other one is still usable.
    assign fo_trig_c = AUTO_FAILOVER && !ok[cur_sel_o] && ok[~cur_sel_o];

    // Ready is a function of live health inputs, so it cannot be registered.
    assign bus.req_ready_o = !rst_i && (state == ST_IDLE) && !fo_trig_c;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;

    // State register and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            tgt         <= RESET_SEL;
            own         <= 1'b0;
            cnt         <= '0;
            mux_sel_o   <= RESET_SEL;
            cur_sel_o   <= RESET_SEL;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            failover_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_n;
            tgt         <= tgt_n;
            own         <= own_n;
            cnt         <= cnt_n;
            mux_sel_o   <= mux_n;
            cur_sel_o   <= cur_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_err_q   <= rsp_err_n;
            failover_o  <= failover_n;
            busy_o      <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        tgt_n       = tgt;
        own_n       = own;
        cnt_n       = cnt;
        mux_n       = mux_sel_o;
        cur_n       = cur_sel_o;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        failover_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fo_trig_c) begin
                    tgt_n      = ~cur_sel_o;
                    own_n      = 1'b0;
                    failover_n = 1'b1;
                    mux_n      = ~cur_sel_o;
                    cnt_n      = CNT_LOAD;
                    state_n    = ST_SWITCH;
                end else if (bus.req_valid_i) begin
                    if (bus.req_sel_i == cur_sel_o) begin
                        rsp_valid_n = 1'b1;
                        state_n     = ST_RESP;
                    end else if (!ok[bus.req_sel_i]) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        state_n     = ST_RESP;
                    end else begin
                        tgt_n   = bus.req_sel_i;
                        own_n   = 1'b1;
                        mux_n   = bus.req_sel_i;
                        cnt_n   = CNT_LOAD;
                        state_n = ST_SWITCH;
                    end
                end
            end

            // Response pulse was launched on entry; just return.
            ST_RESP: begin
                state_n = ST_IDLE;
            end

            // Target health is checked on every window cycle, including the last.
            ST_SWITCH: begin
                if (!ok[tgt]) begin
                    mux_n   = cur_sel_o;
                    cnt_n   = CNT_LOAD;
                    state_n = ST_REVERT;
                end else if (cnt == '0) begin
                    cur_n       = tgt;
                    rsp_valid_n = own;
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            // Full settle window back onto the original source; health ignored.
            ST_REVERT: begin
                if (cnt == '0) begin
                    rsp_valid_n = own;
                    rsp_err_n   = own;
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencer for the glitch-free clock mux, running on an always-on reference clock. It accepts clock-select requests over a valid/ready handshake and checks that the target source is healthy. It drives the mux select, waits a programmable settle window for the mux's internal handover to finish, then reports completion or error. It also performs automatic failover when the active source is lost, and reverts an in-flight switch whose target dies.

## Interface
Parameters:
- SETTLE_CYCLES, 16: clk_i cycles to hold after any mux_sel_o change before the switch counts as complete. Must be ≥ 1 and must cover DELAY+1 edges of the slowest source.
- RESET_SEL, 0: mux_sel_o / cur_sel_o value in reset (0 = clock A, 1 = clock B).
- AUTO_FAILOVER, 1: 1 enables automatic switch-away when the active source's ok drops.

Ports:
- clk_i  input  1  always-on reference clock; all logic is on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  switch request valid.
- req_sel_i  input  1  requested source (0 = A, 1 = B); stable while req_valid_i is high.
- req_ready_o  output  1  request accepted when high together with req_valid_i.
- rsp_valid_o  output  1  one-cycle completion pulse for an accepted request.
- rsp_err_o  output  1  qualified by rsp_valid_o; 1 = switch refused or reverted.
- clk_a_ok_i  input  1  clock A healthy (already synchronous to clk_i).
- clk_b_ok_i  input  1  clock B healthy (already synchronous to clk_i).
- mux_sel_o  output  1  registered select to the mux sel_i.
- cur_sel_o  output  1  last completed, settled selection.
- busy_o  output  1  high in any state other than IDLE.
- failover_o  output  1  one-cycle pulse when an automatic failover starts.

## Operation
- Reset values: mux_sel_o = cur_sel_o = RESET_SEL. req_ready_o, rsp_valid_o, rsp_err_o, busy_o and failover_o are 0. State is IDLE.
- req_ready_o = (state == IDLE) && !fo_trig, where fo_trig = AUTO_FAILOVER && !ok[cur_sel_o] && ok[~cur_sel_o]. req_ready_o is low during the reset cycle.
- States: IDLE, RESP, SWITCH, REVERT. Each state carries a target bit tgt and a request-owned flag own.
- IDLE, fo_trig: tgt = ~cur_sel_o, own = 0. Pulse failover_o. Toggle mux_sel_o. Load the counter with SETTLE_CYCLES-1. Go to SWITCH.
- IDLE, accept with req_sel_i == cur_sel_o: go to RESP with err = 0, no toggle.
- IDLE, accept with target not ok: go to RESP with err = 1, no toggle.
- IDLE, accept with target ok: tgt = req_sel_i, own = 1. Toggle mux_sel_o, load the counter, go to SWITCH.
- fo_trig has priority over a same-cycle request. The request is not accepted because ready is low.
- RESP: rsp_valid_o = 1 for one cycle with the stored err, then go to IDLE.
- SWITCH, ok[tgt] low: set mux_sel_o = cur_sel_o, reload the counter, go to REVERT. This check runs every cycle, including the last one.
- SWITCH, counter == 0 and ok[tgt] high: cur_sel_o <= tgt. If own, pulse rsp_valid_o with err = 0. Go to IDLE.
- SWITCH, otherwise: decrement the counter.
- REVERT: count down the full window. At zero go to IDLE with cur_sel_o unchanged. If own, pulse rsp_valid_o with err = 1.
- REVERT does not monitor ok. If both sources are dead the block parks in IDLE and fo_trig stays false.
- Counter width is $clog2(SETTLE_CYCLES+1). The counter never wraps: it holds at 0 outside the countdown states.
- Every accepted request yields exactly one rsp_valid_o. Failovers yield none.
- Reset mid-switch: mux_sel_o returns to RESET_SEL immediately and asynchronously. No response is issued for the aborted request.

## Timing
- Accept at edge 0.
- Same-target or refused request: rsp_valid_o is high in cycle 1.
- Good switch: mux_sel_o changes after edge 0. The SWITCH window lasts SETTLE_CYCLES cycles (counter values SETTLE_CYCLES-1 down to 0). rsp_valid_o and the cur_sel_o update occur one cycle after the window ends, i.e. SETTLE_CYCLES+1 edges after accept.
- The next request can be accepted in the same cycle as rsp_valid_o, because the state is IDLE.
- Revert at window cycle k: mux_sel_o restores on the next edge. rsp_valid_o with err = 1 follows SETTLE_CYCLES edges after that.
- failover_o is registered and aligned with the first cycle in which mux_sel_o has toggled.

## Test plan
- Reset with RESET_SEL = 0, both ok: mux_sel_o = 0, cur_sel_o = 0, busy_o = 0 during and after reset. req_ready_o is 0 during reset and 1 after.
- SETTLE_CYCLES = 4, request B: mux_sel_o = 1 from cycle 1. rsp_valid_o = 1 with rsp_err_o = 0 at cycle 5. cur_sel_o = 1 from cycle 5.
- Request B while clk_b_ok_i = 0: rsp_valid_o with err = 1 at cycle 1. mux_sel_o stays 0.
- Drop clk_b_ok_i in the third SWITCH cycle: mux_sel_o returns to 0 one edge later. rsp_err_o = 1 four cycles after that. cur_sel_o stays 0.
- Active A with clk_a_ok_i falling and a simultaneous request for A: failover_o pulses and the request is held (ready = 0). cur_sel_o = 1 after the window. The held request is then accepted and answered with err = 1 (A not ok).
- Assert rst_i mid-SWITCH: outputs return to reset values asynchronously, and no rsp_valid_o is seen afterwards.
